// File: rtl/pipeline_pkg.sv
// Shared pipeline types and widths for the EX/MEM -> MEM/WB stage.
package pipeline_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PUSH_LO = 2'd1,
        POP_HI  = 2'd2
    } mem_state_e;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 16;
    localparam int REG_ADDR_W = 3;
    localparam int BUS_W      = 32;
    localparam int FLAGS_W    = 3;
    localparam int STACK_TOP  = (2 ** DEF_ADDR_W) - 1;
endpackage

// File: rtl/data_memory.sv
// Word-addressed data RAM: one synchronous write port, two asynchronous read ports.
module data_memory #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);
    logic [DATA_W-1:0] mem_r [2**ADDR_W];

    // Write port; contents are intentionally never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_r[raddr_a];
    assign rdata_b = mem_r[raddr_b];
endmodule

// File: rtl/memory_stage_unit.sv
// Memory stage: data memory access, 32-bit PC push/pop over two cycles, registered MEM/WB bundle.
module memory_stage_unit
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MR,
    input  logic                  MW,
    input  logic                  WB,
    input  logic                  JWSP,
    input  logic                  Stack_PC,
    input  logic                  Stack_Flags,
    input  logic                  SP,
    input  logic                  SPOP,
    input  logic [REG_ADDR_W-1:0] WB_Address,
    input  logic [BUS_W-1:0]      Data,
    input  logic [BUS_W-1:0]      Address,
    output logic                  Stall,
    output logic                  SP_Extra,
    output logic                  SP_Extra_Inc,
    output logic [FLAGS_W-1:0]    Flags_From_Memory,
    output logic                  MEM_Stack_Flags,
    output logic                  WB_Out,
    output logic [REG_ADDR_W-1:0] WB_Address_Out,
    output logic [DATA_W-1:0]     Result,
    output logic                  PC_Load,
    output logic [BUS_W-1:0]      Return_PC
);
    mem_state_e          state_r, state_next_s;
    logic [ADDR_W-1:0]   a_s, addr_r, mem_waddr_s;
    logic [DATA_W-1:0]   lo_r, mem_wdata_s, rd_a_s, rd_b_s;
    logic                stall_s, sp_extra_s, sp_extra_inc_s, mem_we_s;
    logic                wb_out_r, pc_load_r;
    logic [REG_ADDR_W-1:0] wb_address_r;
    logic [DATA_W-1:0]   result_r;
    logic [BUS_W-1:0]    return_pc_r;
    logic                unused_s;

    assign a_s      = Address[ADDR_W-1:0];
    assign unused_s = ^{Address[BUS_W-1:ADDR_W], JWSP, SP, SPOP};

    data_memory #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dmem (
        .clk     (clk),
        .we      (mem_we_s),
        .waddr   (mem_waddr_s),
        .wdata   (mem_wdata_s),
        .raddr_a (a_s),
        .rdata_a (rd_a_s),
        .raddr_b (addr_r + ADDR_W'(1)),
        .rdata_b (rd_b_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state: MW wins over MR when both request a PC stack access.
    always_comb begin
        state_next_s = IDLE;
        case (state_r)
            IDLE: begin
                if (Stack_PC && MW) begin
                    state_next_s = PUSH_LO;
                end else if (Stack_PC && MR) begin
                    state_next_s = POP_HI;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PUSH_LO: state_next_s = IDLE;
            POP_HI:  state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Outputs and memory write port; writes are blocked while reset is held.
    always_comb begin
        stall_s        = 1'b0;
        sp_extra_s     = 1'b0;
        sp_extra_inc_s = 1'b0;
        mem_we_s       = 1'b0;
        mem_waddr_s    = a_s;
        mem_wdata_s    = Data[DATA_W-1:0];
        case (state_r)
            IDLE: begin
                stall_s  = Stack_PC & (MW | MR);
                mem_we_s = MW & rst;
                if (Stack_PC) begin
                    mem_wdata_s = Data[2*DATA_W-1:DATA_W];
                end else begin
                    mem_wdata_s = Data[DATA_W-1:0];
                end
            end
            PUSH_LO: begin
                sp_extra_s  = 1'b1;
                mem_we_s    = rst;
                mem_waddr_s = addr_r - ADDR_W'(1);
                mem_wdata_s = lo_r;
            end
            POP_HI: begin
                sp_extra_s     = 1'b1;
                sp_extra_inc_s = 1'b1;
            end
            default: begin
                stall_s = 1'b0;
            end
        endcase
    end

    // Capture address and low word for the second half of a PC push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r <= '0;
            lo_r   <= '0;
        end else if (state_r == IDLE && stall_s) begin
            addr_r <= a_s;
            lo_r   <= MW ? Data[DATA_W-1:0] : rd_a_s;
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_out_r     <= 1'b0;
            wb_address_r <= '0;
            result_r     <= '0;
            pc_load_r    <= 1'b0;
            return_pc_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    pc_load_r <= 1'b0;
                    if (stall_s) begin
                        wb_out_r <= 1'b0;
                    end else begin
                        wb_out_r     <= WB;
                        wb_address_r <= WB_Address;
                        result_r     <= (MR && !MW) ? rd_a_s : Data[DATA_W-1:0];
                    end
                end
                POP_HI: begin
                    wb_out_r    <= 1'b0;
                    pc_load_r   <= 1'b1;
                    return_pc_r <= {rd_b_s, lo_r};
                end
                default: begin
                    wb_out_r  <= 1'b0;
                    pc_load_r <= 1'b0;
                end
            endcase
        end
    end

    assign Stall             = stall_s;
    assign SP_Extra          = sp_extra_s;
    assign SP_Extra_Inc      = sp_extra_inc_s;
    assign Flags_From_Memory = rd_a_s[FLAGS_W-1:0];
    assign MEM_Stack_Flags   = MR & Stack_Flags;
    assign WB_Out            = wb_out_r;
    assign WB_Address_Out    = wb_address_r;
    assign Result            = result_r;
    assign PC_Load           = pc_load_r;
    assign Return_PC         = return_pc_r;
endmodule

// File: tb/tb_memory_stage_unit.sv
// Self-checking bench: directed scenarios plus random traffic against an array-based memory model.
module tb_memory_stage_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MR, MW, WB, JWSP, Stack_PC, Stack_Flags, SP, SPOP;
    logic [2:0]  WB_Address;
    logic [31:0] Data, Address;
    logic        Stall, SP_Extra, SP_Extra_Inc, MEM_Stack_Flags, WB_Out, PC_Load;
    logic [2:0]  Flags_From_Memory, WB_Address_Out;
    logic [15:0] Result;
    logic [31:0] Return_PC;

    int checks = 0;
    int failures = 0;
    logic [15:0] mdl [2048];

    memory_stage_unit dut (
        .clk(clk), .rst(rst), .MR(MR), .MW(MW), .WB(WB), .JWSP(JWSP),
        .Stack_PC(Stack_PC), .Stack_Flags(Stack_Flags), .SP(SP), .SPOP(SPOP),
        .WB_Address(WB_Address), .Data(Data), .Address(Address),
        .Stall(Stall), .SP_Extra(SP_Extra), .SP_Extra_Inc(SP_Extra_Inc),
        .Flags_From_Memory(Flags_From_Memory), .MEM_Stack_Flags(MEM_Stack_Flags),
        .WB_Out(WB_Out), .WB_Address_Out(WB_Address_Out), .Result(Result),
        .PC_Load(PC_Load), .Return_PC(Return_PC)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_zero();
        {MR, MW, WB, JWSP, Stack_PC, Stack_Flags, SP, SPOP} = 8'd0;
        WB_Address = 3'd0;
        Data       = 32'd0;
        Address    = 32'd0;
    endtask

    task automatic rand_in();
        {MR, MW, WB, JWSP, Stack_PC, Stack_Flags, SP, SPOP} = 8'($urandom);
        WB_Address = 3'($urandom);
        Data       = $urandom;
        Address    = $urandom;
    endtask

    task automatic normal_op(input logic mr, input logic mw, input logic wb, input logic sf,
                             input logic [2:0] wa, input logic [31:0] data, input logic [10:0] a);
        logic [15:0] exp_res;
        exp_res = (mr && !mw) ? mdl[a] : data[15:0];
        MR = mr; MW = mw; WB = wb; Stack_Flags = sf; Stack_PC = 1'b0;
        {JWSP, SP, SPOP} = 3'($urandom);
        WB_Address = wa; Data = data; Address = {21'($urandom), a};
        @(negedge clk);
        chk("stall_normal", 32'(Stall), 32'd0);
        chk("sp_extra_normal", 32'(SP_Extra), 32'd0);
        chk("flags_mem", 32'(Flags_From_Memory), 32'(mdl[a][2:0]));
        chk("mem_stack_flags", 32'(MEM_Stack_Flags), 32'(mr & sf));
        if (mw) mdl[a] = data[15:0];
        @(posedge clk); #1;
        chk("wb_out", 32'(WB_Out), 32'(wb));
        chk("wb_addr_out", 32'(WB_Address_Out), 32'(wa));
        chk("result", 32'(Result), 32'(exp_res));
        chk("pc_load_normal", 32'(PC_Load), 32'd0);
    endtask

    task automatic push_op(input logic [10:0] a, input logic [31:0] data);
        logic [10:0] am1;
        am1 = a - 11'd1;
        rand_in();
        MW = 1'b1; Stack_PC = 1'b1; Data = data; Address = {21'($urandom), a};
        @(negedge clk);
        chk("push_stall", 32'(Stall), 32'd1);
        chk("push_sp_extra1", 32'(SP_Extra), 32'd0);
        mdl[a] = data[31:16];
        @(posedge clk); #1;
        chk("push_wb1", 32'(WB_Out), 32'd0);
        rand_in();
        @(negedge clk);
        chk("push_stall2", 32'(Stall), 32'd0);
        chk("push_sp_extra", 32'(SP_Extra), 32'd1);
        chk("push_sp_inc", 32'(SP_Extra_Inc), 32'd0);
        mdl[am1] = data[15:0];
        @(posedge clk); #1;
        chk("push_wb2", 32'(WB_Out), 32'd0);
        chk("push_pc_load", 32'(PC_Load), 32'd0);
    endtask

    task automatic pop_op(input logic [10:0] a);
        logic [10:0] ap1;
        logic [31:0] exp_pc;
        ap1 = a + 11'd1;
        exp_pc = {mdl[ap1], mdl[a]};
        rand_in();
        MR = 1'b1; MW = 1'b0; Stack_PC = 1'b1; Address = {21'($urandom), a};
        @(negedge clk);
        chk("pop_stall", 32'(Stall), 32'd1);
        chk("pop_sp_extra1", 32'(SP_Extra), 32'd0);
        @(posedge clk); #1;
        chk("pop_pc_load1", 32'(PC_Load), 32'd0);
        rand_in();
        @(negedge clk);
        chk("pop_stall2", 32'(Stall), 32'd0);
        chk("pop_sp_extra", 32'(SP_Extra), 32'd1);
        chk("pop_sp_inc", 32'(SP_Extra_Inc), 32'd1);
        @(posedge clk); #1;
        chk("pop_pc_load", 32'(PC_Load), 32'd1);
        chk("pop_return_pc", Return_PC, exp_pc);
        chk("pop_wb", 32'(WB_Out), 32'd0);
    endtask

    initial begin
        logic [10:0] ra;
        set_zero();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_out", 32'(WB_Out), 32'd0);
        chk("rst_result", 32'(Result), 32'd0);
        chk("rst_pc_load", 32'(PC_Load), 32'd0);
        chk("rst_return_pc", Return_PC, 32'd0);
        chk("rst_sp_extra", 32'(SP_Extra), 32'd0);
        rst = 1'b1;

        // Fill every word so the model is fully defined.
        for (int i = 0; i < 2048; i++) begin
            normal_op(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, $urandom, 11'(i));
        end

        // Store then load, boundary stack push/pop, flag restore, wrap-around push.
        normal_op(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_00AB, 11'd5);
        normal_op(1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 32'hDEAD_0000, 11'd5);
        push_op(11'd2047, 32'h0001_0234);
        normal_op(1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 32'd0, 11'd2047);
        normal_op(1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 32'd0, 11'd2046);
        pop_op(11'd2046);
        normal_op(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_0005, 11'd10);
        normal_op(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'd0, 11'd10);
        push_op(11'd0, 32'hBEEF_1234);
        normal_op(1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 32'd0, 11'd0);
        normal_op(1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 32'd0, 11'd2047);
        normal_op(1'b1, 1'b1, 1'b1, 1'b0, 3'd6, 32'h0000_7777, 11'd20);

        // Reset asserted while the low word of a push is pending.
        rand_in();
        MW = 1'b1; Stack_PC = 1'b1; Data = 32'hAAAA_5555; Address = 32'd100;
        @(negedge clk);
        chk("rstpush_stall", 32'(Stall), 32'd1);
        mdl[100] = 16'hAAAA;
        @(posedge clk); #1;
        set_zero();
        #2 rst = 1'b0;
        #1;
        chk("rstpush_sp_extra", 32'(SP_Extra), 32'd0);
        chk("rstpush_stall2", 32'(Stall), 32'd0);
        chk("rstpush_wb_out", 32'(WB_Out), 32'd0);
        chk("rstpush_result", 32'(Result), 32'd0);
        chk("rstpush_return_pc", Return_PC, 32'd0);
        @(posedge clk); #1;
        chk("rstpush_pc_load", 32'(PC_Load), 32'd0);
        rst = 1'b1;
        normal_op(1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 32'd0, 11'd100);
        normal_op(1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 32'd0, 11'd99);

        // Random mix of ordinary accesses, bubbles and PC stack operations.
        for (int n = 0; n < 400; n++) begin
            ra = 11'($urandom);
            case ($urandom_range(0, 9))
                7:       push_op(ra, $urandom);
                8:       pop_op(ra);
                9:       normal_op(1'b0, 1'b0, 1'b0, 1'b0, 3'($urandom), $urandom, ra);
                default: normal_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                                   3'($urandom), $urandom, ra);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
